inv_key_schedule: RTL and testbench

Sequential AES-128 inverse key expansion. It takes the final (round-10) round key and produces round keys 10 down to 0, one per accepted handshake, so the decryption datapath can consume round keys in the order it applies them. It walks the forward Rcon sequence (01h…36h) backwards, computing each constant internally by GF(2^8) division by x, and applies SubWord through four instances of the team's forward byte S-box. It sits between the key register and the inverse-cipher round core.

---
 rtl/inv_key_schedule.sv | 168 ++++++++++++++++
 tb/tb_inv_key_schedule.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_schedule.sv
// rtl/inv_key_schedule.sv - AES-128 inverse key expansion, round 10 down to round 0, one key per handshake

// Forward AES byte S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  logic [7:0] w_x2, w_x3, w_x6, w_x7, w_x14, w_x15, w_x30, w_x31;
  logic [7:0] w_x62, w_x63, w_x126, w_x127, w_inv;
  logic [7:0] w_r1, w_r2, w_r3, w_r4;

  // Inverse as x^254 via a square-and-multiply chain; 0 maps to 0 naturally.
  always_comb begin
    w_x2   = gf_mul(i_byte, i_byte);
    w_x3   = gf_mul(w_x2, i_byte);
    w_x6   = gf_mul(w_x3, w_x3);
    w_x7   = gf_mul(w_x6, i_byte);
    w_x14  = gf_mul(w_x7, w_x7);
    w_x15  = gf_mul(w_x14, i_byte);
    w_x30  = gf_mul(w_x15, w_x15);
    w_x31  = gf_mul(w_x30, i_byte);
    w_x62  = gf_mul(w_x31, w_x31);
    w_x63  = gf_mul(w_x62, i_byte);
    w_x126 = gf_mul(w_x63, w_x63);
    w_x127 = gf_mul(w_x126, i_byte);
    w_inv  = gf_mul(w_x127, w_x127);
    w_r1   = rotl1(w_inv);
    w_r2   = rotl1(w_r1);
    w_r3   = rotl1(w_r2);
    w_r4   = rotl1(w_r3);
    o_byte = w_inv ^ w_r1 ^ w_r2 ^ w_r3 ^ w_r4 ^ 8'h63;
  end

endmodule

// Walks the key schedule backwards so the inverse cipher gets keys in application order.
module inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic [3:0]   round_out,
  output logic         last
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic [7:0]   r_rcon;

  logic         w_load;
  logic         w_step;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_p0, w_p1, w_p2, w_p3;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [127:0] w_prev_key;
  logic [7:0]   w_rcon_nxt;

  assign w_w0 = r_key[127:96];
  assign w_w1 = r_key[95:64];
  assign w_w2 = r_key[63:32];
  assign w_w3 = r_key[31:0];

  // Undo the forward XOR chain; w3' feeds the SubWord path of w0'.
  assign w_p3  = w_w3 ^ w_w2;
  assign w_p2  = w_w2 ^ w_w1;
  assign w_p1  = w_w1 ^ w_w0;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
        .i_byte (w_rot[8*g +: 8]),
        .o_byte (w_sub[8*g +: 8])
      );
    end
  endgenerate

  assign w_p0       = w_w0 ^ w_sub ^ {r_rcon, 24'h000000};
  assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

  // Rcon runs backwards by dividing by x in GF(2^8); 01h steps to the unused 8Dh.
  assign w_rcon_nxt = r_rcon[0] ? ((r_rcon >> 1) ^ 8'h8d) : (r_rcon >> 1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, status outputs and datapath strobes; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    busy        = 1'b0;
    key_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        key_valid = 1'b1;
        if (key_ready) begin
          if (r_round == 4'd0) w_state_nxt = ST_IDLE;
          else                 w_step      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Key, round index and rcon registers; they hold during stalls and after the final key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key   <= 128'h0;
      r_round <= 4'd0;
      r_rcon  <= 8'h36;
    end else if (w_load) begin
      r_key   <= key_in;
      r_round <= 4'd10;
      r_rcon  <= 8'h36;
    end else if (w_step) begin
      r_key   <= w_prev_key;
      r_round <= r_round - 4'd1;
      r_rcon  <= w_rcon_nxt;
    end
  end

  assign key_out   = r_key;
  assign round_out = r_round;
  assign last      = key_valid & (r_round == 4'd0);

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb/tb_inv_key_schedule.sv - randomized self-checking bench for inv_key_schedule

module tb_inv_key_schedule;

  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_ready = 1'b0;
  logic         busy;
  logic         key_valid;
  logic [127:0] key_out;
  logic [3:0]   round_out;
  logic         last;

  inv_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_out   (key_out),
    .round_out (round_out),
    .last      (last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  logic [7:0] sbox_tab [0:255];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 32'h11b;
    end
    return p[7:0];
  endfunction

  // Brute-force inverse search plus the affine map, built once into a table.
  function automatic logic [7:0] sbox_calc(input logic [7:0] v);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    for (int y = 1; y < 256; y++)
      if (gmul(v, y[7:0]) == 8'h01) inv = y[7:0];
    s = 8'h63;
    for (int i = 0; i < 8; i++)
      s[i] = s[i] ^ inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
    return s;
  endfunction

  function automatic logic [7:0] rcon_of(input int j);
    logic [7:0] t [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    return t[j];
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] x);
    logic [31:0] r = {x[23:0], x[31:24]};
    return {sbox_tab[r[31:24]], sbox_tab[r[23:16]], sbox_tab[r[15:8]], sbox_tab[r[7:0]]};
  endfunction

  // Round key r recovered from the round-10 key by running the word recurrence w[i] backwards.
  function automatic logic [127:0] ref_key(input logic [127:0] k10, input int r);
    logic [31:0] w [0:43];
    w[40] = k10[127:96]; w[41] = k10[95:64]; w[42] = k10[63:32]; w[43] = k10[31:0];
    for (int i = 39; i >= 0; i--) begin
      if ((i + 4) % 4 == 0) w[i] = w[i + 4] ^ sub_rot(w[i + 3]) ^ {rcon_of((i + 4) / 4), 24'h0};
      else                  w[i] = w[i + 4] ^ w[i + 3];
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Standard forward expansion, returning the round-10 key.
  function automatic logic [127:0] fwd10(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    w[0] = k0[127:96]; w[1] = k0[95:64]; w[2] = k0[63:32]; w[3] = k0[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) t = sub_rot(t) ^ {rcon_of(i / 4), 24'h0};
      w[i] = w[i - 4] ^ t;
    end
    return {w[40], w[41], w[42], w[43]};
  endfunction

  logic         m_active = 1'b0;
  logic [127:0] m_key = '0;
  logic [127:0] m_k10 = '0;
  int           m_round = 0;

  // Reference model: which round key should be on the output after each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_key    <= '0;
      m_round  <= 0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_k10    <= key_in;
        m_key    <= key_in;
        m_round  <= 10;
      end
    end else if (key_ready) begin
      if (m_round == 0) m_active <= 1'b0;
      else begin
        m_round <= m_round - 1;
        m_key   <= ref_key(m_k10, m_round - 1);
      end
    end
  end

  logic [127:0] obs [0:15];
  int           dut_hs = 0;

  // Compare every output against the model mid-cycle; record accepted keys.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("key_valid", {127'h0, key_valid}, {127'h0, m_active});
      chk("busy", {127'h0, busy}, {127'h0, m_active});
      chk("last", {127'h0, last}, {127'h0, m_active && (m_round == 0)});
      chk("key_out", key_out, m_key);
      chk("round_out", {124'h0, round_out}, m_round);
      if (key_valid && key_ready) begin
        obs[round_out] <= key_out;
        dut_hs <= dut_hs + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high; 1: random ready; 2: random ready with start held high throughout.
  task automatic run(input logic [127:0] k, input int mode, input bit trail);
    int base;
    int cyc;
    base = dut_hs;
    start = 1'b1;
    key_in = k;
    key_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    tick();
    start = (mode == 2);
    cyc = 0;
    while (m_active && cyc < 400) begin
      key_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("run_done_busy", {127'h0, busy}, 128'h0);
    chk("handshakes", dut_hs - base, 11);
    if (trail) repeat (2) tick();
  endtask

  task automatic chk_vectors(input string tag);
    chk({tag, "_r10"}, obs[10], K10);
    chk({tag, "_r9"}, obs[9], K9);
    chk({tag, "_r1"}, obs[1], K1);
    chk({tag, "_r0"}, obs[0], K0);
  endtask

  initial begin
    logic [127:0] kr;
    int cyc;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(i[7:0]);

    chk("sbox_00", {120'h0, sbox_tab[8'h00]}, 128'h63);
    chk("sbox_01", {120'h0, sbox_tab[8'h01]}, 128'h7c);
    chk("sbox_53", {120'h0, sbox_tab[8'h53]}, 128'hed);
    chk("model_r9", ref_key(K10, 9), K9);
    chk("model_r1", ref_key(K10, 1), K1);
    chk("model_r0", ref_key(K10, 0), K0);
    chk("model_fwd", fwd10(K0), K10);

    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_key_out", key_out, 128'h0);
    chk("reset_round", {124'h0, round_out}, 128'h0);
    tick();

    run(K10, 0, 1'b1);
    chk_vectors("ready1");

    run(K10, 1, 1'b1);
    chk_vectors("stall");

    run(K10, 2, 1'b1);
    chk_vectors("startspam");

    start = 1'b1; key_in = K10; key_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (m_round != 5 && cyc < 50) begin tick(); cyc++; end
    chk("reached_round5", {124'h0, round_out}, 128'h5);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {127'h0, key_valid}, 128'h0);
    chk("midrst_busy", {127'h0, busy}, 128'h0);
    chk("midrst_key", key_out, 128'h0);
    chk("midrst_round", {124'h0, round_out}, 128'h0);
    tick();
    rst = 1'b0;
    tick();
    run(K10, 0, 1'b1);
    chk_vectors("after_rst");

    run(128'h0, 1, 1'b1);
    chk("zero_r0", obs[0], ref_key(128'h0, 0));
    chk("zero_fwd", fwd10(obs[0]), 128'h0);

    kr = {$urandom, $urandom, $urandom, $urandom};
    run(K10, 0, 1'b0);
    chk("b2b_first_r0", obs[0], K0);
    run(kr, 1, 1'b1);
    chk("b2b_second_r10", obs[10], kr);
    chk("b2b_second_fwd", fwd10(obs[0]), kr);

    for (int n = 0; n < 4; n++) begin
      kr = {$urandom, $urandom, $urandom, $urandom};
      run(kr, 1, 1'b1);
      chk("rand_fwd", fwd10(obs[0]), kr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
